wb_reg_bank: RTL and testbench
==============================

Name: wb_reg_bank

Overview:
- Parametrised Wishbone classic-pipelined slave holding NREGS read/write control registers of DATA_W bits each.
- Successor to the fixed two-register 32-bit generated banks. Adds:
  - width and depth generics
  - real read-back of register contents
  - per-register write-strobe outputs
  - error termination for unmapped addresses
  - optional byte-lane writes
- Sits between the Wishbone interconnect and a block's control logic.

Parameters:
- NREGS, 2, number of registers; 1..256.
- DATA_W, 32, bus and register width; one of 8, 16, 32, 64.
- RST_VAL, all zero, packed [NREGS*DATA_W-1:0] reset values; register i occupies bits [i*DATA_W +: DATA_W].
- Derived localparams (not overridable):
  - ALSB = clog2(DATA_W/8)
  - AW = max(1, clog2(NREGS))

Ports:
- clk_i  in  1  clock; all logic on its rising edge.
- rst_i  in  1  synchronous active-high reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_adr_i  in  [AW+ALSB-1:ALSB]  word address.
- wb_sel_i  in  DATA_W/8  byte selects.
- wb_we_i  in  1  write enable.
- wb_dat_i  in  DATA_W  write data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination (unmapped index).
- wb_rty_o  out  1  tied 0.
- wb_stall_o  out  1  stall.
- wb_dat_o  out  DATA_W  read data.
- regs_o  out  NREGS*DATA_W  current register contents.
- wr_stb_o  out  NREGS  one-cycle pulse in the cycle after register i was updated.

Behaviour:
- Reset is synchronous, active-high, clk_i only. While rst_i=1 at an edge:
  - all registers load RST_VAL
  - rip, wip, pipeline valid bits, wb_ack_o, wb_err_o, wr_stb_o clear to 0
  - wb_dat_o clears to 0
- Reset mid-transaction drops the pending ack/err; the master must restart the cycle.
- Handshake and tracking:
  - en = wb_cyc_i & wb_stb_i.
  - wb_stall_o = en & !(wb_ack_o | wb_err_o), combinational.
  - rip is set by en & !we and cleared on the read termination.
  - wip is the same for writes.
  - A new request is accepted only when the matching rip/wip is 0, so there is exactly one outstanding transaction per direction.
- Read path, request accepted in cycle T:
  - Index decode and mux are combinational in T.
  - wb_dat_o and the ack are registered: wb_ack_o=1 in T+1 with wb_dat_o = reg[idx].
  - Read latency is 1.
- Write path, request accepted in cycle T:
  - Address, data and sel are registered (wr_*_d0) and are valid in T+1.
  - The selected register updates at the end of T+1 and is visible on regs_o in T+2.
  - wack is registered: wb_ack_o=1 in T+2; wr_stb_o[idx]=1 in T+2 only.
  - Write latency is 2.
- Unmapped index (idx >= NREGS, only possible when NREGS is not a power of two):
  - Read: wb_err_o=1 in T+1 and wb_dat_o=0.
  - Write: wb_err_o=1 in T+2; no register changes and no strobe.
- wb_ack_o and wb_err_o are never high together. Each lasts exactly one cycle per request.
- wb_dat_o holds its last value when no read completes.
- A read of register i in the same cycle its write commits returns the old value; the read mux samples before the edge.
- Dropping cyc_i/stb_i after acceptance does not cancel the transaction; the ack is still issued.

Optional Feature:
- Macro: WB_REG_BANK_BYTE_SEL_EN.
- Defined: only byte lanes with wr_sel_d0[b]=1 are updated; wb_sel_i=0 still acks and pulses wr_stb_o.
- Undefined: wb_sel_i is ignored and every write updates the full word.

Decomposition:
- Package wb_reg_bank_pkg:
  - clog2 constant function
  - byte-merge function (old, new, sel) -> word
  - localparam for the rty tie-off
- Sub-module wb_slave_hs implements the rip/wip tracking, stall and ack/err muxing. It is reusable by all generated register banks.
- wb_reg_bank holds the register array, decode and the write/read pipelines.

Test Plan:
- Reset check: NREGS=4, DATA_W=32, RST_VAL reg1=0x123. Release rst_i -> regs_o shows reg1=0x00000123 and others 0. Read addr 1 -> ack at T+1 with wb_dat_o=0x00000123.
- Write then read: write 0xDEADBEEF to addr 3 at T -> wb_ack_o at T+2 and wr_stb_o=4'b1000 at T+2. A subsequent read of addr 3 returns 0xDEADBEEF.
- Unmapped index: NREGS=3, write to addr 3 -> wb_err_o at T+2, no ack, regs_o unchanged. Read addr 3 -> wb_err_o at T+1, wb_dat_o=0.
- Byte lanes: with WB_REG_BANK_BYTE_SEL_EN, reg0=0x11223344, write 0xAABBCCDD with sel=4'b0101 -> reg0=0x11BB33DD. Without the macro -> reg0=0xAABBCCDD.
- Stall and back-to-back: hold stb for two reads -> stall=1 until each ack, second ack two cycles after the first, no duplicate ack.
- Reset mid-write: assert rst_i at T+1 of a write -> no ack, no wr_stb_o, register equals RST_VAL.

Source files
------------

// File: rtl/wb_reg_bank_pkg.sv
// Shared types and helpers for the Wishbone register bank family.
// Holds the address-width helper, the byte-lane merge and the retry tie-off.
package wb_reg_bank_pkg;

    // Retry is never signalled by these banks.
    localparam logic WB_RTY_TIE = 1'b0;

    // Widest supported bus; the byte-merge helper works on this width.
    localparam int MAX_DATA_W = 64;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 32'sd0;
        v = 32'sd1;
        while (v < n) begin
            v = v * 32'sd2;
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Take each byte from new_w where sel is set, otherwise keep old_w.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [7:0]            sel
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int b = 32'sd0; b < 32'sd8; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_slave_hs.sv
// Wishbone pipelined-slave handshake: one outstanding read and one outstanding
// write, registered ack/err, combinational stall. Shared by the generated banks.
// A read is not accepted while a write is in flight, so a read termination can
// never land in the same cycle as a write termination and ack/err stay unique.
module wb_slave_hs (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cyc_i,
    input  logic stb_i,
    input  logic we_i,
    input  logic rd_map_i,   // read index decodes to a real register
    input  logic wr_term_i,  // write stage-0 is valid: terminate next cycle
    input  logic wr_map_i,   // stage-0 write index decodes to a real register
    output logic rd_acc_o,
    output logic wr_acc_o,
    output logic ack_o,
    output logic err_o,
    output logic stall_o
);

    logic w_en;
    logic r_rip;
    logic r_wip;
    logic r_wr_done;
    logic r_ack;
    logic r_err;

    assign w_en     = cyc_i & stb_i;
    assign rd_acc_o = w_en & ~we_i & ~r_rip & ~r_wip;
    assign wr_acc_o = w_en &  we_i & ~r_wip;
    assign ack_o    = r_ack;
    assign err_o    = r_err;
    assign stall_o  = w_en & ~(r_ack | r_err);

    // Track in-progress read/write; a read always terminates the cycle after it is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rip     <= 1'b0;
            r_wip     <= 1'b0;
            r_wr_done <= 1'b0;
        end else begin
            if (rd_acc_o) begin
                r_rip <= 1'b1;
            end else if (r_rip) begin
                r_rip <= 1'b0;
            end else begin
                r_rip <= r_rip;
            end
            r_wr_done <= wr_term_i;
            if (wr_acc_o) begin
                r_wip <= 1'b1;
            end else if (r_wr_done) begin
                r_wip <= 1'b0;
            end else begin
                r_wip <= r_wip;
            end
        end
    end

    // Registered terminations: reads one cycle after accept, writes one cycle after stage 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= (rd_acc_o & rd_map_i) | (wr_term_i & wr_map_i);
            r_err <= (rd_acc_o & ~rd_map_i) | (wr_term_i & ~wr_map_i);
        end
    end

endmodule

// File: rtl/wb_reg_bank.sv
// Parametrised Wishbone pipelined register bank: NREGS x DATA_W control registers
// with read-back, per-register write strobes and error termination on unmapped
// indices. Optional macro WB_REG_BANK_BYTE_SEL_EN enables byte-lane writes;
// without it wb_sel_i is ignored and writes replace the full word.
module wb_reg_bank
    import wb_reg_bank_pkg::*;
#(
    parameter int                     NREGS   = 2,
    parameter int                     DATA_W  = 32,
    parameter logic [NREGS*DATA_W-1:0] RST_VAL = {(NREGS*DATA_W){1'b0}},
    localparam int                    ALSB    = clog2(DATA_W / 8),
    localparam int                    AW      = (clog2(NREGS) > 0) ? clog2(NREGS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic [AW+ALSB-1:ALSB]     wb_adr_i,
    input  logic [DATA_W/8-1:0]       wb_sel_i,
    input  logic                      wb_we_i,
    input  logic [DATA_W-1:0]         wb_dat_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    output logic                      wb_stall_o,
    output logic [DATA_W-1:0]         wb_dat_o,
    output logic [NREGS*DATA_W-1:0]   regs_o,
    output logic [NREGS-1:0]          wr_stb_o
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_map;
    logic              w_wr_map;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              r_wr_vld_d0;
    logic [AW-1:0]     r_wr_adr_d0;
    logic [DATA_W-1:0] r_wr_dat_d0;
    logic [NREGS-1:0]  r_wr_stb;
    logic [DATA_W-1:0] r_dat;
`ifdef WB_REG_BANK_BYTE_SEL_EN
    logic [DATA_W/8-1:0] r_wr_sel_d0;
`else
    logic                w_unused_sel;
    assign w_unused_sel = ^wb_sel_i;
`endif

    wb_slave_hs u_hs (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cyc_i     (wb_cyc_i),
        .stb_i     (wb_stb_i),
        .we_i      (wb_we_i),
        .rd_map_i  (w_rd_map),
        .wr_term_i (r_wr_vld_d0),
        .wr_map_i  (w_wr_map),
        .rd_acc_o  (w_rd_acc),
        .wr_acc_o  (w_wr_acc),
        .ack_o     (wb_ack_o),
        .err_o     (wb_err_o),
        .stall_o   (wb_stall_o)
    );

    // Indices at or above NREGS exist only for non-power-of-two depths.
    assign w_rd_map = ({1'b0, wb_adr_i} < NREGS_W);
    assign w_wr_map = ({1'b0, r_wr_adr_d0} < NREGS_W);

    // Read mux samples the array before the edge; unmapped indices give zero.
    always_comb begin
        w_rd_data = {DATA_W{1'b0}};
        for (int i = 32'sd0; i < NREGS; i++) begin
            w_rd_data = (wb_adr_i == AW'(i)) ? r_regs[i] : w_rd_data;
        end
    end

    // Read data register: loads on read accept, otherwise holds the last read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dat <= {DATA_W{1'b0}};
        end else if (w_rd_acc) begin
            r_dat <= w_rd_data;
        end else begin
            r_dat <= r_dat;
        end
    end

    // Write stage 0: capture address, data and lane selects of an accepted write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_vld_d0 <= 1'b0;
            r_wr_adr_d0 <= {AW{1'b0}};
            r_wr_dat_d0 <= {DATA_W{1'b0}};
`ifdef WB_REG_BANK_BYTE_SEL_EN
            r_wr_sel_d0 <= {(DATA_W/8){1'b0}};
`endif
        end else begin
            r_wr_vld_d0 <= w_wr_acc;
            if (w_wr_acc) begin
                r_wr_adr_d0 <= wb_adr_i;
                r_wr_dat_d0 <= wb_dat_i;
`ifdef WB_REG_BANK_BYTE_SEL_EN
                r_wr_sel_d0 <= wb_sel_i;
`endif
            end else begin
                r_wr_adr_d0 <= r_wr_adr_d0;
                r_wr_dat_d0 <= r_wr_dat_d0;
`ifdef WB_REG_BANK_BYTE_SEL_EN
                r_wr_sel_d0 <= r_wr_sel_d0;
`endif
            end
        end
    end

    // Register array: commit stage-0 write; unmapped indices match no register.
    always_ff @(posedge clk_i) begin
        for (int i = 32'sd0; i < NREGS; i++) begin
            if (rst_i) begin
                r_regs[i] <= RST_VAL[i*DATA_W +: DATA_W];
            end else if (r_wr_vld_d0 && (r_wr_adr_d0 == AW'(i))) begin
`ifdef WB_REG_BANK_BYTE_SEL_EN
                r_regs[i] <= DATA_W'(byte_merge(MAX_DATA_W'(r_regs[i]),
                                                MAX_DATA_W'(r_wr_dat_d0),
                                                8'(r_wr_sel_d0)));
`else
                r_regs[i] <= r_wr_dat_d0;
`endif
            end else begin
                r_regs[i] <= r_regs[i];
            end
        end
    end

    // Per-register strobe, high in the cycle the new value first appears on regs_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_stb <= {NREGS{1'b0}};
        end else begin
            for (int i = 32'sd0; i < NREGS; i++) begin
                r_wr_stb[i] <= r_wr_vld_d0 && (r_wr_adr_d0 == AW'(i));
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign wb_dat_o = r_dat;
    assign wr_stb_o = r_wr_stb;
    assign wb_rty_o = WB_RTY_TIE;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Scoreboard bench for wb_reg_bank: a 4-register bank (reg1 resets to 0x123)
// and a 3-register bank (index 3 unmapped) share clock and reset.
module tb_wb_reg_bank;

    localparam logic [127:0] RST4 = 128'h00000000_00000000_00000123_00000000;
`ifdef WB_REG_BANK_BYTE_SEL_EN
    localparam logic [31:0] EXP_BL = 32'h11BB33DD;
    localparam logic [31:0] EXP_Z  = 32'h00000000;
`else
    localparam logic [31:0] EXP_BL = 32'hAABBCCDD;
    localparam logic [31:0] EXP_Z  = 32'h00000055;
`endif

    typedef struct {
        logic         err;
        logic [31:0]  dat;
        logic [3:0]   stb;
        logic [127:0] regs;
        int           cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cyc4 = 1'b0, stb4 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0, we = 1'b0;
    logic [1:0]  adr = 2'd0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat = 32'h0;

    logic ack4, err4, rty4, stall4, ack3, err3, rty3, stall3;
    logic [31:0]  dat4, dat3;
    logic [127:0] regs4;
    logic [95:0]  regs3;
    logic [3:0]   wstb4;
    logic [2:0]   wstb3;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    logic [127:0] m4;
    logic [95:0]  m3;
    logic [31:0]  lr4, lr3;

    wb_reg_bank #(.NREGS(4), .DATA_W(32), .RST_VAL(RST4)) dut4 (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc4), .wb_stb_i(stb4),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat),
        .wb_ack_o(ack4), .wb_err_o(err4), .wb_rty_o(rty4), .wb_stall_o(stall4),
        .wb_dat_o(dat4), .regs_o(regs4), .wr_stb_o(wstb4)
    );

    wb_reg_bank #(.NREGS(3), .DATA_W(32)) dut3 (
        .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc3), .wb_stb_i(stb3),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat),
        .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3), .wb_stall_o(stall3),
        .wb_dat_o(dat3), .regs_o(regs3), .wr_stb_o(wstb3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pop and compare one termination of the selected bank, or check it is idle.
    task automatic mon_one(input int d);
        logic a, er;
        logic [31:0] dt;
        logic [3:0] st;
        logic [127:0] rg;
        exp_t e;
        int qs;
        if (d == 4) begin
            a = ack4; er = err4; dt = dat4; st = wstb4; rg = regs4; qs = q4.size();
        end else begin
            a = ack3; er = err3; dt = dat3; st = {1'b0, wstb3}; rg = {32'h0, regs3}; qs = q3.size();
        end
        if (a || er) begin
            chk($sformatf("dut%0d_ack_err_excl", d), 128'(a & er), 128'(0));
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d_spurious_term: ack=%0b err=%0b with nothing outstanding", d, a, er);
            end else begin
                if (d == 4) e = q4.pop_front();
                else        e = q3.pop_front();
                chk($sformatf("dut%0d_err", d),     128'(er), 128'(e.err));
                chk($sformatf("dut%0d_ack", d),     128'(a),  128'(!e.err));
                chk($sformatf("dut%0d_rdata", d),   128'(dt), 128'(e.dat));
                chk($sformatf("dut%0d_wr_stb", d),  128'(st), 128'(e.stb));
                chk($sformatf("dut%0d_regs", d),    rg,       e.regs);
                chk($sformatf("dut%0d_latency", d), 128'(cyc_cnt), 128'(e.cyc));
            end
        end else begin
            chk($sformatf("dut%0d_idle_wr_stb", d), 128'(st), 128'(0));
        end
    endtask

    // Monitor: checks every termination against the scoreboard, away from the edge.
    always @(negedge clk) begin
        if (!rst) begin
            mon_one(4);
            mon_one(3);
        end
    end

    // Issue one request, push its expectation, hold stb until it terminates.
    task automatic issue(input int d, input logic w, input logic [1:0] a, input logic [31:0] data,
                         input logic [3:0] s, input logic e_err, input logic [31:0] e_dat,
                         input logic [3:0] e_stb, input logic [127:0] e_regs, input int lat);
        exp_t it;
        bit done;
        it.err = e_err; it.dat = e_dat; it.stb = e_stb; it.regs = e_regs;
        it.cyc = cyc_cnt + lat;
        we = w; adr = a; dat = data; sel = s;
        if (d == 4) begin q4.push_back(it); cyc4 = 1'b1; stb4 = 1'b1; end
        else        begin q3.push_back(it); cyc3 = 1'b1; stb3 = 1'b1; end
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (d == 4) done = ack4 | err4;
            else        done = ack3 | err3;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_timeout: no termination for adr %0d within 8 cycles", d, a);
        end
        @(posedge clk); #1;
        cyc4 = 1'b0; stb4 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int t;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_regs4", regs4, RST4);
        chk("reset_regs3", {32'h0, regs3}, 128'h0);
        chk("reset_ack4", 128'(ack4 | err4), 128'(0));
        chk("reset_dat4", 128'(dat4), 128'(0));
        chk("reset_wstb4", 128'(wstb4), 128'(0));
        chk("reset_stall4", 128'(stall4), 128'(0));
        chk("rty_tied", 128'({rty4, rty3}), 128'(0));
        @(posedge clk); #1;
        m4 = RST4; m3 = 96'h0; lr4 = 32'h0; lr3 = 32'h0;

        // Reset value read-back.
        issue(4, 1'b0, 2'd1, 32'h0, 4'hF, 1'b0, 32'h00000123, 4'h0, m4, 1);
        lr4 = 32'h00000123;
        // Write then read.
        m4[96 +: 32] = 32'hDEADBEEF;
        issue(4, 1'b1, 2'd3, 32'hDEADBEEF, 4'hF, 1'b0, lr4, 4'b1000, m4, 2);
        issue(4, 1'b0, 2'd3, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 4'h0, m4, 1);
        lr4 = 32'hDEADBEEF;
        // Byte lanes.
        m4[0 +: 32] = 32'h11223344;
        issue(4, 1'b1, 2'd0, 32'h11223344, 4'hF, 1'b0, lr4, 4'b0001, m4, 2);
        m4[0 +: 32] = EXP_BL;
        issue(4, 1'b1, 2'd0, 32'hAABBCCDD, 4'b0101, 1'b0, lr4, 4'b0001, m4, 2);
        issue(4, 1'b0, 2'd0, 32'h0, 4'hF, 1'b0, EXP_BL, 4'h0, m4, 1);
        lr4 = EXP_BL;
        m4[64 +: 32] = EXP_Z;
        issue(4, 1'b1, 2'd2, 32'h00000055, 4'h0, 1'b0, lr4, 4'b0100, m4, 2);

        // Three-register bank: mapped write, unmapped write and reads.
        m3[64 +: 32] = 32'hCAFEF00D;
        issue(3, 1'b1, 2'd2, 32'hCAFEF00D, 4'hF, 1'b0, lr3, 4'b0100, {32'h0, m3}, 2);
        issue(3, 1'b1, 2'd3, 32'h12345678, 4'hF, 1'b1, lr3, 4'h0, {32'h0, m3}, 2);
        issue(3, 1'b0, 2'd2, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, 4'h0, {32'h0, m3}, 1);
        lr3 = 32'hCAFEF00D;
        issue(3, 1'b0, 2'd3, 32'h0, 4'hF, 1'b1, 32'h0, 4'h0, {32'h0, m3}, 1);
        lr3 = 32'h0;

        // Back-to-back reads with stb held: acks at T+1 and T+3.
        t = cyc_cnt;
        e.err = 1'b0; e.dat = 32'hDEADBEEF; e.stb = 4'h0; e.regs = m4;
        e.cyc = t + 1; q4.push_back(e);
        e.cyc = t + 3; q4.push_back(e);
        we = 1'b0; adr = 2'd3; cyc4 = 1'b1; stb4 = 1'b1;
        @(negedge clk); chk("b2b_stall_T", 128'(stall4), 128'(1));
        @(negedge clk); chk("b2b_stall_T1", 128'(stall4), 128'(0));
        @(negedge clk); chk("b2b_stall_T2", 128'(stall4), 128'(1));
        @(negedge clk); chk("b2b_stall_T3", 128'(stall4), 128'(0));
        @(posedge clk); #1;
        cyc4 = 1'b0; stb4 = 1'b0;
        @(posedge clk); #1;

        // Reset during the write's stage-0 cycle: no ack, no strobe, reset value kept.
        we = 1'b1; adr = 2'd1; dat = 32'hFFFF0000; sel = 4'hF; cyc4 = 1'b1; stb4 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; cyc4 = 1'b0; stb4 = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m4 = RST4; m3 = 96'h0; lr4 = 32'h0; lr3 = 32'h0;
        @(negedge clk);
        chk("rstmid_regs4", regs4, RST4);
        chk("rstmid_regs3", {32'h0, regs3}, 128'h0);
        chk("rstmid_dat4", 128'(dat4), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        issue(4, 1'b0, 2'd1, 32'h0, 4'hF, 1'b0, 32'h00000123, 4'h0, m4, 1);

        chk("q4_drained", 128'(q4.size()), 128'(0));
        chk("q3_drained", 128'(q3.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
